fa_tri_style_adder: RTL and testbench

- Registered ripple-carry adder of WIDTH bits; each bit is built from three independently coded 1-bit full-adder cells:
  - dataflow: continuous boolean equations.
  - behavioral: procedural if/else.
  - case: truth-table case on {ci,a,b}.
- STYLE selects which cell chain drives the primary result.
- Used as a self-checking arithmetic primitive in datapaths and as the golden full-adder truth-table block for regression.

---
 rtl/fa_tri_style_pkg.sv | 18 +
 rtl/fa_style_cell.sv | 53 +++++
 rtl/fa_tri_style_adder.sv | 118 +++++++++++
 tb/tb_fa_tri_style_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_tri_style_pkg.sv
// Shared constants and helpers for the tri-style full-adder block.
package fa_tri_style_pkg;

  localparam int FA_STYLE_DATAFLOW = 0;
  localparam int FA_STYLE_BEHAV    = 1;
  localparam int FA_STYLE_CASE     = 2;

  localparam int FA_MAX_WIDTH      = 32;

  // Map any out-of-range style selector onto the dataflow coding.
  function automatic int fa_style_norm(input int style);
    if (style == FA_STYLE_BEHAV || style == FA_STYLE_CASE) begin
      return style;
    end
    return FA_STYLE_DATAFLOW;
  endfunction

endpackage

// File: rtl/fa_style_cell.sv
// 1-bit full adder with a compile-time choice of coding style:
// dataflow equations, procedural if/else, or a {ci,a,b} truth table.
module fa_style_cell
  import fa_tri_style_pkg::*;
#(
  parameter int STYLE = FA_STYLE_DATAFLOW
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  generate
    if (STYLE == FA_STYLE_BEHAV) begin : g_behav
      // Equal operands pass the carry straight to the sum and generate/kill the
      // carry from a; unequal operands propagate the incoming carry.
      always_comb begin
        s  = 1'b0;
        co = 1'b0;
        if (a == b) begin
          s  = ci;
          co = a;
        end else begin
          s  = ~ci;
          co = ci;
        end
      end
    end else if (STYLE == FA_STYLE_CASE) begin : g_case
      // Full truth table indexed by {ci,a,b}.
      always_comb begin
        s  = 1'b0;
        co = 1'b0;
        case ({ci, a, b})
          3'b000: begin s = 1'b0; co = 1'b0; end
          3'b001: begin s = 1'b1; co = 1'b0; end
          3'b010: begin s = 1'b1; co = 1'b0; end
          3'b011: begin s = 1'b0; co = 1'b1; end
          3'b100: begin s = 1'b1; co = 1'b0; end
          3'b101: begin s = 1'b0; co = 1'b1; end
          3'b110: begin s = 1'b0; co = 1'b1; end
          3'b111: begin s = 1'b1; co = 1'b1; end
          default: begin s = 1'b0; co = 1'b0; end
        endcase
      end
    end else begin : g_dataflow
      assign s  = a ^ b ^ ci;
      assign co = (a & b) | (ci & (a ^ b));
    end
  endgenerate

endmodule

// File: rtl/fa_tri_style_adder.sv
// Registered WIDTH-bit ripple-carry adder built from fa_style_cell chains.
// STYLE picks the chain driving s/co (values >= 3 fall back to dataflow).
// Optional macro FA_TRI_STYLE_CROSSCHECK_EN builds all three chains and adds a
// registered 'mismatch' output flagging any disagreement between them; without
// it only the selected chain exists.
module fa_tri_style_adder
  import fa_tri_style_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int STYLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int SEL = fa_style_norm(STYLE);

  logic [WIDTH-1:0] sum_sel;
  logic             co_sel;

`ifdef FA_TRI_STYLE_CROSSCHECK_EN
  logic [WIDTH:0]   c_df, c_bh, c_cs;
  logic [WIDTH-1:0] s_df, s_bh, s_cs;
  logic             diff;
  logic             mismatch_p1;

  assign c_df[0] = ci;
  assign c_bh[0] = ci;
  assign c_cs[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_style_cell #(.STYLE(FA_STYLE_DATAFLOW)) u_df (
      .a(a[i]), .b(b[i]), .ci(c_df[i]), .s(s_df[i]), .co(c_df[i+1])
    );
    fa_style_cell #(.STYLE(FA_STYLE_BEHAV)) u_bh (
      .a(a[i]), .b(b[i]), .ci(c_bh[i]), .s(s_bh[i]), .co(c_bh[i+1])
    );
    fa_style_cell #(.STYLE(FA_STYLE_CASE)) u_cs (
      .a(a[i]), .b(b[i]), .ci(c_cs[i]), .s(s_cs[i]), .co(c_cs[i+1])
    );
  end

  if (SEL == FA_STYLE_BEHAV) begin : g_sel_bh
    assign sum_sel = s_bh;
    assign co_sel  = c_bh[WIDTH];
  end else if (SEL == FA_STYLE_CASE) begin : g_sel_cs
    assign sum_sel = s_cs;
    assign co_sel  = c_cs[WIDTH];
  end else begin : g_sel_df
    assign sum_sel = s_df;
    assign co_sel  = c_df[WIDTH];
  end

  assign diff = (s_df != s_bh) || (s_df != s_cs) ||
                (c_df[WIDTH] != c_bh[WIDTH]) || (c_df[WIDTH] != c_cs[WIDTH]);

  // Cross-check flag travels with the result; idle cycles report no mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_p1 <= 1'b0;
    end else if (in_valid) begin
      mismatch_p1 <= diff;
    end else begin
      mismatch_p1 <= 1'b0;
    end
  end

  assign mismatch = mismatch_p1;
`else
  logic [WIDTH:0] c_sel;

  assign c_sel[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_style_cell #(.STYLE(SEL)) u_cell (
      .a(a[i]), .b(b[i]), .ci(c_sel[i]), .s(sum_sel[i]), .co(c_sel[i+1])
    );
  end

  assign co_sel = c_sel[WIDTH];
`endif

  // ---- stage p1: output register ----
  logic [WIDTH-1:0] s_p1;
  logic             co_p1;
  logic             vld_p1;

  // Capture the selected chain on valid; hold data (and ignore X inputs) when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1   <= '0;
      co_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1  <= sum_sel;
        co_p1 <= co_sel;
      end
    end
  end

  assign s         = s_p1;
  assign co        = co_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_fa_tri_style_adder.sv
// Directed bench for fa_tri_style_adder: 1-bit truth table in all three styles,
// 8-bit wrap / hold / reset cases, and a 4-bit random sweep against a + b + ci.
module tb_fa_tri_style_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // 1-bit instances, one per style
  logic       a1, b1, ci1, v1;
  logic       ov_w1s0, ov_w1s1, ov_w1s2;
  logic [0:0] s_w1s0, s_w1s1, s_w1s2;
  logic       co_w1s0, co_w1s1, co_w1s2;

  // 8-bit instance (case style)
  logic [7:0] a8, b8, s_w8;
  logic       ci8, v8, ov_w8, co_w8;

  // 4-bit instance, STYLE=3 falls back to dataflow
  logic [3:0] a4, b4, s_w4;
  logic       ci4, v4, ov_w4, co_w4;

`ifdef FA_TRI_STYLE_CROSSCHECK_EN
  logic mm_w1s0, mm_w1s1, mm_w1s2, mm_w8, mm_w4;
`endif

  fa_tri_style_adder #(.WIDTH(1), .STYLE(0)) u_w1s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .ci(ci1),
    .out_valid(ov_w1s0), .s(s_w1s0), .co(co_w1s0)
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
    , .mismatch(mm_w1s0)
`endif
  );

  fa_tri_style_adder #(.WIDTH(1), .STYLE(1)) u_w1s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .ci(ci1),
    .out_valid(ov_w1s1), .s(s_w1s1), .co(co_w1s1)
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
    , .mismatch(mm_w1s1)
`endif
  );

  fa_tri_style_adder #(.WIDTH(1), .STYLE(2)) u_w1s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .ci(ci1),
    .out_valid(ov_w1s2), .s(s_w1s2), .co(co_w1s2)
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
    , .mismatch(mm_w1s2)
`endif
  );

  fa_tri_style_adder #(.WIDTH(8), .STYLE(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .ci(ci8),
    .out_valid(ov_w8), .s(s_w8), .co(co_w8)
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
    , .mismatch(mm_w8)
`endif
  );

  fa_tri_style_adder #(.WIDTH(4), .STYLE(3)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .ci(ci4),
    .out_valid(ov_w4), .s(s_w4), .co(co_w4)
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
    , .mismatch(mm_w4)
`endif
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-derived truth table, bit i corresponds to {ci,a,b} = i
  logic [7:0] tbl_s;
  logic [7:0] tbl_co;
  logic [2:0] vec;
  logic [4:0] exp4;

  initial begin
    tbl_s  = 8'b1001_0110;
    tbl_co = 8'b1110_1000;
    rst_n = 1'b0;
    {a1, b1, ci1, v1} = '0;
    {a8, b8, ci8, v8} = '0;
    {a4, b4, ci4, v4} = '0;

    // Reset state, checked with no clock edge involved
    #3;
    chk("rst_w8_s",  s_w8,  8'h00);
    chk("rst_w8_co", co_w8, 1'b0);
    chk("rst_w8_ov", ov_w8, 1'b0);
    chk("rst_w1_ov", ov_w1s1, 1'b0);
    chk("rst_w4_s",  s_w4,  4'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, all three styles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec = i[2:0];
      {ci1, a1, b1} = vec;
      v1 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("w1s0_s_%0d", i),  s_w1s0,  tbl_s[i]);
      chk($sformatf("w1s0_co_%0d", i), co_w1s0, tbl_co[i]);
      chk($sformatf("w1s1_s_%0d", i),  s_w1s1,  tbl_s[i]);
      chk($sformatf("w1s1_co_%0d", i), co_w1s1, tbl_co[i]);
      chk($sformatf("w1s2_s_%0d", i),  s_w1s2,  tbl_s[i]);
      chk($sformatf("w1s2_co_%0d", i), co_w1s2, tbl_co[i]);
      chk($sformatf("w1_ov_%0d", i),   {ov_w1s0, ov_w1s1, ov_w1s2}, 3'b111);
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
      chk($sformatf("w1_mm_%0d", i), {mm_w1s0, mm_w1s1, mm_w1s2}, 3'b000);
`endif
    end
    @(negedge clk);
    v1 = 1'b0;

    // 8-bit carry wrap
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap_s",  s_w8,  8'h00);
    chk("wrap_co", co_w8, 1'b1);
    chk("wrap_ov", ov_w8, 1'b1);

    // 8-bit mixed pattern, then two idle cycles with junk on the inputs
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; ci8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("mix_s",  s_w8,  8'h8D);
    chk("mix_co", co_w8, 1'b0);
    chk("mix_ov", ov_w8, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a8 = 'x; b8 = 'x; ci8 = 'x; v8 = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("hold_ov_%0d", k), ov_w8, 1'b0);
      chk($sformatf("hold_s_%0d", k),  s_w8,  8'h8D);
      chk($sformatf("hold_co_%0d", k), co_w8, 1'b0);
    end

    // Reset asserted between edges while a result is valid
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_s",  s_w8,  8'h33);
    chk("pre_rst_ov", ov_w8, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s",  s_w8,  8'h00);
    chk("mid_rst_co", co_w8, 1'b0);
    chk("mid_rst_ov", ov_w8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h03; b8 = 8'h04; ci8 = 1'b1; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s",  s_w8,  8'h08);
    chk("post_rst_co", co_w8, 1'b0);
    chk("post_rst_ov", ov_w8, 1'b1);
    @(negedge clk);
    v8 = 1'b0;

    // 4-bit random sweep against a + b + ci
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a4  = 4'($urandom_range(15, 0));
      b4  = 4'($urandom_range(15, 0));
      ci4 = 1'($urandom_range(1, 0));
      v4  = 1'b1;
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'b0000, ci4};
      @(posedge clk);
      #1;
      chk($sformatf("rnd_sum_%0d", n), {co_w4, s_w4}, exp4);
      chk($sformatf("rnd_ov_%0d", n),  ov_w4, 1'b1);
`ifdef FA_TRI_STYLE_CROSSCHECK_EN
      chk($sformatf("rnd_mm_%0d", n),  mm_w4, 1'b0);
`endif
    end
    @(negedge clk);
    v4 = 1'b0;
    @(posedge clk);
    #1;
    chk("rnd_idle_ov", ov_w4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
